instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 39 +++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared opcode, machine-word and FSM definitions for the instruction encoder
// and the control decoder.
package instr_encoder_pkg;

  localparam int OPC_W  = 4;
  localparam int FLD_W  = 5;
  localparam int WORD_W = OPC_W + FLD_W;
  localparam int IMM_W  = 8;

  typedef enum logic [OPC_W-1:0] {
    OP_LOAD   = 4'b0000,
    OP_STORE  = 4'b0001,
    OP_XOR    = 4'b0010,
    OP_BNE    = 4'b0011,
    OP_ADD    = 4'b0100,
    OP_MOV    = 4'b0101,
    OP_LSHIFT = 4'b0110,
    OP_RSHIFT = 4'b0111,
    OP_LOADI  = 4'b1000,
    OP_PARI   = 4'b1001
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_EMIT_LO = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  function automatic logic is_valid_op(input logic [OPC_W-1:0] op);
    return op <= OP_PARI;
  endfunction

  function automatic logic [WORD_W-1:0] encode_word(input logic [OPC_W-1:0] op,
                                                    input logic [FLD_W-1:0] fld);
    return {op, fld};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Turns mnemonic records into 9-bit machine words and writes them sequentially
// into instruction memory; loadi expands into a high-nibble and low-nibble word.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  op,
  input  logic [FLD_W-1:0]  operand,
  input  logic [IMM_W-1:0]  imm,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              full,
  output logic              err,
  output state_t            state_dbg
);

  localparam logic [AW-1:0] LAST = '1;

  state_t              state, state_n;
  logic [AW-1:0]       addr_n, slot;
  logic                wen_q, wen_n;
  logic [WORD_W-1:0]   data_n;
  logic                full_n, err_n;
  logic [3:0]          lo_q, lo_n;
  logic                xfer;

  // Handshake: a record is consumed only on a cycle where in_valid and
  // in_ready are both high; in_ready never depends on in_valid.
  assign in_ready = reset && !flush &&
                    ((state == ST_IDLE) || ((state == ST_EMIT) && (wr_addr != LAST)));
  assign xfer     = in_valid && in_ready;
  assign wr_en    = wen_q && reset;
  assign state_dbg = state;

  // Address the next accepted word lands on: past the word being written now.
  assign slot = (state == ST_EMIT) ? wr_addr + AW'(1) : wr_addr;

  always_comb begin
    state_n = state;
    addr_n  = (wen_q && (wr_addr != LAST)) ? wr_addr + AW'(1) : wr_addr;
    wen_n   = 1'b0;
    data_n  = wr_data;
    full_n  = full;
    err_n   = err;
    lo_n    = lo_q;

    case (state)
      ST_IDLE: ;
      ST_EMIT: begin
        state_n = (wr_addr == LAST) ? ST_FULL : ST_IDLE;
        full_n  = (wr_addr == LAST);
      end
      ST_EMIT_LO: begin
        state_n = ST_EMIT;
        wen_n   = 1'b1;
        data_n  = encode_word(OP_LOADI, {1'b1, lo_q});
      end
      ST_FULL: ;
      default: state_n = ST_IDLE;
    endcase

    if (xfer) begin
      if (!is_valid_op(op)) begin
        err_n = 1'b1;
      end else if (op == OP_LOADI) begin
        // Both halves must fit; a split loadi would corrupt the program.
        if (slot == LAST) begin
          err_n = 1'b1;
        end else begin
          state_n = ST_EMIT_LO;
          wen_n   = 1'b1;
          data_n  = encode_word(OP_LOADI, {1'b0, imm[7:4]});
          lo_n    = imm[3:0];
        end
      end else begin
        state_n = ST_EMIT;
        wen_n   = 1'b1;
        data_n  = encode_word(op, operand);
      end
    end

    if (flush) begin
      state_n = ST_IDLE;
      addr_n  = '0;
      wen_n   = 1'b0;
      data_n  = wr_data;
      full_n  = 1'b0;
      lo_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      wr_addr <= '0;
      wen_q   <= 1'b0;
      wr_data <= '0;
      full    <= 1'b0;
      err     <= 1'b0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      wr_addr <= addr_n;
      wen_q   <= wen_n;
      wr_data <= data_n;
      full    <= full_n;
      err     <= err_n;
      lo_q    <= lo_n;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: an AW=8 and an AW=2 instance share stimulus and are
// compared every cycle against a queue-based model of the emitted word stream.
module tb_instr_encoder;

  logic       clk;
  logic       reset, flush, in_valid;
  logic [3:0] op;
  logic [4:0] operand;
  logic [7:0] imm;

  logic       rdy0, wen0, full0, err0;
  logic [7:0] addr0;
  logic [8:0] data0;
  logic [1:0] st0;
  logic       rdy1, wen1, full1, err1;
  logic [1:0] addr1;
  logic [8:0] data1;
  logic [1:0] st1;

  instr_encoder #(.AW(8)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .op(op), .operand(operand), .imm(imm), .wr_en(wen0), .wr_addr(addr0),
    .wr_data(data0), .full(full0), .err(err0), .state_dbg(st0)
  );

  instr_encoder #(.AW(2)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .op(op), .operand(operand), .imm(imm), .wr_en(wen1), .wr_addr(addr1),
    .wr_data(data1), .full(full1), .err(err1), .state_dbg(st1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pending words as {addr[7:0], word[8:0]}
  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  int          maxa[2] = '{255, 3};
  int          nxt[2];
  bit          err_m[2];
  bit          full_m[2];
  logic [8:0]  last_m[2];
  bit          model_known = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic int qsize(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [16:0] qhead(input int i);
    return (i == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic qpush(input int i, input logic [16:0] v);
    if (i == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endtask

  task automatic qpop(input int i);
    if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
  endtask

  task automatic qclear(input int i);
    if (i == 0) exp_q0.delete(); else exp_q1.delete();
  endtask

  function automatic bit exp_ready(input int i);
    return reset && !flush && !full_m[i] && (qsize(i) <= 1) && (nxt[i] <= maxa[i]);
  endfunction

  task automatic model_update(input int i, input bit xfer);
    logic [16:0] h;
    if (!reset) begin
      qclear(i); nxt[i] = 0; err_m[i] = 0; full_m[i] = 0; last_m[i] = '0;
    end else if (flush) begin
      if (qsize(i) > 0) begin h = qhead(i); last_m[i] = h[8:0]; end
      qclear(i); nxt[i] = 0; full_m[i] = 0;
    end else begin
      if (qsize(i) > 0) begin
        h = qhead(i);
        qpop(i);
        last_m[i] = h[8:0];
        if (int'(h[16:9]) == maxa[i]) full_m[i] = 1;
      end
      if (xfer) begin
        if (op > 4'd9) begin
          err_m[i] = 1;
        end else if (op == 4'd8) begin
          if (nxt[i] + 1 > maxa[i]) begin
            err_m[i] = 1;
          end else begin
            qpush(i, {8'(nxt[i]),     4'b1000, 1'b0, imm[7:4]});
            qpush(i, {8'(nxt[i] + 1), 4'b1000, 1'b1, imm[3:0]});
            nxt[i] = nxt[i] + 2;
          end
        end else begin
          qpush(i, {8'(nxt[i]), op, operand});
          nxt[i] = nxt[i] + 1;
        end
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int i);
    logic [7:0]  a;
    logic [8:0]  d;
    logic        en, rd, fu, er;
    logic [16:0] h;
    int          sz;
    if (i == 0) begin
      a = addr0; d = data0; en = wen0; rd = rdy0; fu = full0; er = err0;
    end else begin
      a = {6'b0, addr1}; d = data1; en = wen1; rd = rdy1; fu = full1; er = err1;
    end
    sz = qsize(i);
    h  = (sz > 0) ? qhead(i) : 17'd0;
    chk($sformatf("in_ready%0d", i), 32'(rd), 32'(exp_ready(i)));
    chk($sformatf("wr_en%0d", i), 32'(en), 32'(reset && (sz > 0)));
    chk($sformatf("wr_addr%0d", i), 32'(a),
        (sz > 0) ? 32'(h[16:9]) : 32'((nxt[i] < maxa[i]) ? nxt[i] : maxa[i]));
    chk($sformatf("wr_data%0d", i), 32'(d), (sz > 0) ? 32'(h[8:0]) : 32'(last_m[i]));
    chk($sformatf("full%0d", i), 32'(fu), 32'(full_m[i]));
    chk($sformatf("err%0d", i), 32'(er), 32'(err_m[i]));
  endtask

  // driver
  task automatic step(input bit r, input bit f, input bit v, input logic [3:0] o,
                      input logic [4:0] opd, input logic [7:0] im);
    bit x0, x1;
    reset = r; flush = f; in_valid = v; op = o; operand = opd; imm = im;
    #1;
    if (model_known) begin
      check_dut(0);
      check_dut(1);
    end
    x0 = v && exp_ready(0);
    x1 = v && exp_ready(1);
    @(posedge clk);
    model_update(0, x0);
    model_update(1, x1);
    if (!r) model_known = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1, 0, 0, 4'd0, 5'd0, 8'd0);
  endtask

  initial begin
    bit         r, f, v;
    logic [3:0] o;
    reset = 0; flush = 0; in_valid = 0; op = '0; operand = '0; imm = '0;
    @(negedge clk);

    // reset values
    step(0, 0, 0, 4'd0, 5'd0, 8'd0);
    step(0, 0, 0, 4'd0, 5'd0, 8'd0);
    chk("rst_wr_en", 32'(wen0), 32'd0);
    chk("rst_wr_addr", 32'(addr0), 32'd0);
    chk("rst_wr_data", 32'(data0), 32'd0);
    chk("rst_in_ready", 32'(rdy0), 32'd0);
    idle();

    // add r3 -> word at address 0
    step(1, 0, 1, 4'b0100, 5'b00011, 8'd0);
    chk("add_wr_en", 32'(wen0), 32'd1);
    chk("add_wr_addr", 32'(addr0), 32'd0);
    chk("add_wr_data", 32'(data0), 32'h083);

    // four movs bring dut0 to pointer 5, then loadi A5
    for (int k = 0; k < 4; k++) step(1, 0, 1, 4'b0101, 5'(k + 1), 8'd0);
    idle();
    idle();
    step(1, 0, 1, 4'b1000, 5'd0, 8'hA5);
    chk("loadi_hi_addr", 32'(addr0), 32'd5);
    chk("loadi_hi_data", 32'(data0), 32'h10A);
    chk("loadi_hi_ready", 32'(rdy0), 32'd0);
    idle();
    chk("loadi_lo_addr", 32'(addr0), 32'd6);
    chk("loadi_lo_data", 32'(data0), 32'h115);
    chk("loadi_lo_ready", 32'(rdy0), 32'd1);

    // AW=2 fill with back-to-back xors; fifth not accepted
    step(1, 1, 0, 4'd0, 5'd0, 8'd0);
    for (int k = 0; k < 5; k++) step(1, 0, 1, 4'b0010, 5'(k + 7), 8'd0);
    chk("fill_full", 32'(full1), 32'd1);
    chk("fill_ready", 32'(rdy1), 32'd0);
    chk("fill_addr", 32'(addr1), 32'd3);
    chk("fill_wr_en", 32'(wen1), 32'd0);

    // AW=2 loadi with one slot left
    step(1, 1, 0, 4'd0, 5'd0, 8'd0);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 4'b0101, 5'(k), 8'd0);
    idle();
    step(1, 0, 1, 4'b1000, 5'd0, 8'h3C);
    chk("lastslot_err", 32'(err1), 32'd1);
    chk("lastslot_wr_en", 32'(wen1), 32'd0);
    chk("lastslot_full", 32'(full1), 32'd0);
    step(1, 0, 1, 4'b0101, 5'b10101, 8'd0);
    chk("lastslot_mov_en", 32'(wen1), 32'd1);
    chk("lastslot_mov_addr", 32'(addr1), 32'd3);
    chk("lastslot_mov_data", 32'(data1), 32'h0B5);
    idle();
    idle();

    // illegal opcode, then flush keeps err
    step(1, 0, 1, 4'b1100, 5'd9, 8'd0);
    chk("badop_err", 32'(err0), 32'd1);
    chk("badop_wr_en", 32'(wen0), 32'd0);
    chk("badop_addr", 32'(addr0), 32'd5);
    step(1, 1, 0, 4'd0, 5'd0, 8'd0);
    chk("flush_err", 32'(err0), 32'd1);
    chk("flush_addr", 32'(addr0), 32'd0);
    chk("flush_full1", 32'(full1), 32'd0);

    // reset the cycle after a loadi transfer
    idle();
    step(1, 0, 1, 4'b1000, 5'd0, 8'h5A);
    step(0, 0, 0, 4'd0, 5'd0, 8'd0);
    chk("rstmid_wr_en", 32'(wen0), 32'd0);
    chk("rstmid_addr", 32'(addr0), 32'd0);
    chk("rstmid_data", 32'(data0), 32'd0);
    chk("rstmid_err", 32'(err0), 32'd0);
    idle();
    chk("rstmid_after_en", 32'(wen0), 32'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) >= 2);
      f = ($urandom_range(0, 99) < 3);
      v = ($urandom_range(0, 99) < 70);
      o = ($urandom_range(0, 99) < 85) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      step(r, f, v, o, 5'($urandom), 8'($urandom));
    end
    idle();

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
